// File: rtl/decode_pipe_stage_pkg.sv
// decode_pipe_stage_pkg: shared instruction encodings and field positions for the decode stage
package decode_pipe_stage_pkg;

    // Instruction type field values
    typedef enum logic [1:0] {
        TY_ALU = 2'b00,
        TY_MEM = 2'b01,
        TY_BR  = 2'b10,
        TY_RET = 2'b11
    } instrType_t;

    localparam logic [1:0] OP_BASE = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;

    // Instruction field bit positions
    localparam int INSTR_W  = 33;
    localparam int IMM_FLAG = 32;
    localparam int TYPE_HI  = 31;
    localparam int TYPE_LO  = 30;
    localparam int OP_HI    = 29;
    localparam int OP_LO    = 28;
    localparam int RS1_HI   = 27;
    localparam int RS1_LO   = 23;
    localparam int RS2_HI   = 22;
    localparam int RS2_LO   = 18;
    localparam int RS4_HI   = 4;
    localparam int RS4_LO   = 0;
    localparam int IMMV_HI  = 17;
    localparam int IMMV_LO  = 0;

    localparam int DEFAULT_LINK_REG = 29;

endpackage

// File: rtl/decode_pipe_stage_if.sv
// decode_pipe_stage_if: decode-side inputs, write-back/forward controls and E-register outputs
//   master: drives D-stage instruction, stall/flush, write-back and forward selects; observes E outputs
//   slave : the decode stage itself
interface decode_pipe_stage_if #(
    parameter int DATA_W = 18,
    parameter int PC_W   = 9,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 12
);
    import decode_pipe_stage_pkg::*;

    logic               valid_d;
    logic [INSTR_W-1:0] instr_d;
    logic [PC_W-1:0]    pc_d;
    logic [PC_W-1:0]    pcplus_d;
    logic [CTRL_W-1:0]  ctrl_d;
    logic               stall;
    logic               flush;
    logic               wb_we;
    logic [ADDR_W-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic [2:0]         fwd_sel;

    logic               valid_e;
    logic [CTRL_W-1:0]  ctrl_e;
    logic [DATA_W-1:0]  rd1_e;
    logic [DATA_W-1:0]  rd2_e;
    logic [DATA_W-1:0]  rd4_e;
    logic [DATA_W-1:0]  imm_e;
    logic [ADDR_W-1:0]  rs1_e;
    logic [ADDR_W-1:0]  rs2_e;
    logic [ADDR_W-1:0]  rs4_e;
    logic [ADDR_W-1:0]  rd_e;
    logic [PC_W-1:0]    pc_e;
    logic [PC_W-1:0]    pcplus_e;
    logic [PC_W-1:0]    link_e;

    modport master (
        output valid_d, instr_d, pc_d, pcplus_d, ctrl_d, stall, flush,
               wb_we, wb_addr, wb_data, fwd_sel,
        input  valid_e, ctrl_e, rd1_e, rd2_e, rd4_e, imm_e,
               rs1_e, rs2_e, rs4_e, rd_e, pc_e, pcplus_e, link_e
    );

    modport slave (
        input  valid_d, instr_d, pc_d, pcplus_d, ctrl_d, stall, flush,
               wb_we, wb_addr, wb_data, fwd_sel,
        output valid_e, ctrl_e, rd1_e, rd2_e, rd4_e, imm_e,
               rs1_e, rs2_e, rs4_e, rd_e, pc_e, pcplus_e, link_e
    );

endinterface

// File: rtl/decode_pipe_stage_reg_file_param.sv
// reg_file_param: register file with three bypassed read ports, a link-register read,
//   a general write port (we/wa/wd) and a link write port (linkWe/linkWd) that wins on LINK_REG.
//   Register 0 reads as zero and is never written.
module reg_file_param #(
    parameter int NREGS    = 32,
    parameter int DATA_W   = 18,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 29
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] ra4,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd4,
    output logic [DATA_W-1:0] linkRd,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              linkWe,
    input  logic [DATA_W-1:0] linkWd
);
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs [NREGS];
    logic [ADDR_W-1:0] ra [4];
    logic [DATA_W-1:0] rdv [4];

    assign ra[0] = ra1;
    assign ra[1] = ra2;
    assign ra[2] = ra4;
    assign ra[3] = LINK_A;

    // Reads see this cycle's writes, with the same link-over-general priority as the array
    for (genvar i = 0; i < 4; i++) begin : g_rd
        assign rdv[i] = ra[i] == '0 ? '0 :
                        (linkWe && ra[i] == LINK_A) ? linkWd :
                        (we && ra[i] == wa) ? wd : regs[ra[i]];
    end

    assign rd1    = rdv[0];
    assign rd2    = rdv[1];
    assign rd4    = rdv[2];
    assign linkRd = rdv[3];

    always_ff @(posedge clk)
        for (int r = 0; r < NREGS; r++)
            if (rst) regs[r] <= '0;
            else if (linkWe && r == LINK_REG) regs[r] <= linkWd;
            else if (we && r != 0 && wa == ADDR_W'(r)) regs[r] <= wd;

endmodule

// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: decodes register sources/destination, reads the register file with
//   write-back forwarding, writes the link register on calls, and registers the E stage.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of decode_pipe_stage_if (D inputs, stall/flush, write-back, E outputs)
module decode_pipe_stage
    import decode_pipe_stage_pkg::*;
#(
    parameter int DATA_W   = 18,
    parameter int PC_W     = 9,
    parameter int ADDR_W   = 5,
    parameter int NREGS    = 32,
    parameter int CTRL_W   = 12,
    parameter int LINK_REG = DEFAULT_LINK_REG
) (
    input logic                 clk,
    input logic                 rst,
    decode_pipe_stage_if.slave  bus
);
    logic [INSTR_W-1:0] instr;
    instrType_t         typ;
    logic [1:0]         op;
    logic               imm;
    logic [ADDR_W-1:0]  a1, a2, a4, rd;
    logic               linkWe;
    logic [DATA_W-1:0]  rf1, rf2, rf4, linkRd;
    logic [DATA_W-1:0]  op1, op2, op4;
    logic               loadValid;

    always_comb begin
        instr  = bus.instr_d;
        imm    = instr[IMM_FLAG];
        typ    = instrType_t'(instr[TYPE_HI:TYPE_LO]);
        op     = instr[OP_HI:OP_LO];
        a1     = (typ == TY_RET && op == OP_BASE) ? ADDR_W'(LINK_REG) : ADDR_W'(instr[RS1_HI:RS1_LO]);
        a2     = (!imm && typ == TY_MEM && op == OP_BASE) ? ADDR_W'(instr[RS4_HI:RS4_LO]) : ADDR_W'(instr[RS2_HI:RS2_LO]);
        a4     = ADDR_W'(instr[RS4_HI:RS4_LO]);
        rd     = ((typ == TY_MEM && op == OP_BASE) || (imm && typ != TY_RET && op == OP_BASE)) ?
                 ADDR_W'(instr[RS2_HI:RS2_LO]) : ADDR_W'(instr[RS4_HI:RS4_LO]);
        // A call only commits its link when it actually advances into E
        linkWe = bus.valid_d && typ == TY_BR && op == OP_CALL && !bus.stall && !bus.flush;
        op1    = bus.fwd_sel[0] ? bus.wb_data : rf1;
        op2    = bus.fwd_sel[1] ? bus.wb_data : rf2;
        op4    = bus.fwd_sel[2] ? bus.wb_data : rf4;
        loadValid = bus.valid_d && !bus.flush;
    end

    reg_file_param #(
        .NREGS   (NREGS),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .LINK_REG(LINK_REG)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .ra1   (a1),
        .ra2   (a2),
        .ra4   (a4),
        .rd1   (rf1),
        .rd2   (rf2),
        .rd4   (rf4),
        .linkRd(linkRd),
        .we    (bus.wb_we),
        .wa    (bus.wb_addr),
        .wd    (bus.wb_data),
        .linkWe(linkWe),
        .linkWd(DATA_W'(bus.pc_d))
    );

    // Flush overrides stall; an invalid D slot or flush enters E as a bubble
    always_ff @(posedge clk)
        if (rst) begin
            bus.valid_e  <= 1'b0;
            bus.ctrl_e   <= '0;
            bus.rd1_e    <= '0;
            bus.rd2_e    <= '0;
            bus.rd4_e    <= '0;
            bus.imm_e    <= '0;
            bus.rs1_e    <= '0;
            bus.rs2_e    <= '0;
            bus.rs4_e    <= '0;
            bus.rd_e     <= '0;
            bus.pc_e     <= '0;
            bus.pcplus_e <= '0;
            bus.link_e   <= '0;
        end else if (bus.flush || !bus.stall) begin
            bus.valid_e  <= loadValid;
            bus.ctrl_e   <= loadValid ? bus.ctrl_d : '0;
            bus.rd1_e    <= op1;
            bus.rd2_e    <= op2;
            bus.rd4_e    <= op4;
            bus.imm_e    <= DATA_W'(instr[IMMV_HI:IMMV_LO]);
            bus.rs1_e    <= a1;
            bus.rs2_e    <= a2;
            bus.rs4_e    <= a4;
            bus.rd_e     <= rd;
            bus.pc_e     <= bus.pc_d;
            bus.pcplus_e <= bus.pcplus_d;
            bus.link_e   <= PC_W'(linkRd);
        end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb_decode_pipe_stage: directed and randomized checks of decode_pipe_stage against a post-edge register-state model
module tb_decode_pipe_stage;
    localparam int DW = 18, PW = 9, AW = 5, NR = 32, CW = 12, LR = 29;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_pipe_stage_if #(.DATA_W(DW), .PC_W(PW), .ADDR_W(AW), .CTRL_W(CW)) m();
    decode_pipe_stage_if #(.DATA_W(32), .PC_W(PW), .ADDR_W(4),  .CTRL_W(CW)) s();

    decode_pipe_stage dut (.clk(clk), .rst(rst), .bus(m.slave));
    decode_pipe_stage #(.DATA_W(32), .NREGS(16), .ADDR_W(4), .LINK_REG(13))
        dutS (.clk(clk), .rst(rst), .bus(s.slave));

    assign s.valid_d  = m.valid_d;
    assign s.instr_d  = m.instr_d;
    assign s.pc_d     = m.pc_d;
    assign s.pcplus_d = m.pcplus_d;
    assign s.ctrl_d   = m.ctrl_d;
    assign s.stall    = m.stall;
    assign s.flush    = m.flush;
    assign s.wb_we    = m.wb_we;
    assign s.wb_addr  = m.wb_addr[3:0];
    assign s.wb_data  = 32'(m.wb_data);
    assign s.fwd_sel  = m.fwd_sel;

    int checks = 0, errors = 0;

    logic [DW-1:0] rf [NR];
    logic          eKnown, expValid;
    logic [CW-1:0] expCtrl;
    logic [DW-1:0] eRd1, eRd2, eRd4, eImm;
    logic [AW-1:0] eRs1, eRs2, eRs4, eRd;
    logic [PW-1:0] ePc, ePcp, eLink;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] mk(input bit i, input bit [1:0] t, input bit [1:0] o,
                                       input bit [4:0] r1, input bit [4:0] r2, input bit [17:0] low);
        return {i, t, o, r1, r2, low};
    endfunction

    // Model: register state after this edge's writes; E operands are reads of that state
    task automatic model();
        logic [DW-1:0] nrf [NR];
        logic [32:0]   in;
        logic [1:0]    t, o;
        logic [AW-1:0] a1, a2;
        in = m.instr_d;
        t  = in[31:30];
        o  = in[29:28];
        nrf = rf;
        if (rst) begin
            foreach (nrf[i]) nrf[i] = '0;
            eKnown = 1; expValid = 0; expCtrl = '0;
            eRd1 = '0; eRd2 = '0; eRd4 = '0; eImm = '0;
            eRs1 = '0; eRs2 = '0; eRs4 = '0; eRd = '0;
            ePc = '0; ePcp = '0; eLink = '0;
        end else begin
            if (m.wb_we && m.wb_addr != 0) nrf[m.wb_addr] = m.wb_data;
            if (m.valid_d && t == 2'b10 && o == 2'b01 && !m.stall && !m.flush) nrf[LR] = DW'(m.pc_d);
            if (m.flush || !m.stall) begin
                a1 = (t == 2'b11 && o == 2'b00) ? AW'(LR) : in[27:23];
                a2 = (!in[32] && t == 2'b01 && o == 2'b00) ? in[4:0] : in[22:18];
                eRs1 = a1;
                eRs2 = a2;
                eRs4 = in[4:0];
                eRd  = ((t == 2'b01 && o == 2'b00) || (in[32] && t != 2'b11 && o == 2'b00)) ? in[22:18] : in[4:0];
                eRd1 = m.fwd_sel[0] ? m.wb_data : nrf[a1];
                eRd2 = m.fwd_sel[1] ? m.wb_data : nrf[a2];
                eRd4 = m.fwd_sel[2] ? m.wb_data : nrf[in[4:0]];
                eImm = in[17:0];
                ePc  = m.pc_d;
                ePcp = m.pcplus_d;
                eLink = nrf[LR][PW-1:0];
                expValid = m.valid_d && !m.flush;
                expCtrl  = expValid ? m.ctrl_d : '0;
                eKnown   = expValid;
            end
        end
        rf = nrf;
    endtask

    task automatic cycle();
        model();
        @(posedge clk);
        #1;
        chk("valid_e", m.valid_e, expValid);
        chk("ctrl_e", m.ctrl_e, expCtrl);
        if (eKnown) begin
            chk("rd1_e", m.rd1_e, eRd1);
            chk("rd2_e", m.rd2_e, eRd2);
            chk("rd4_e", m.rd4_e, eRd4);
            chk("imm_e", m.imm_e, eImm);
            chk("rs1_e", m.rs1_e, eRs1);
            chk("rs2_e", m.rs2_e, eRs2);
            chk("rs4_e", m.rs4_e, eRs4);
            chk("rd_e", m.rd_e, eRd);
            chk("pc_e", m.pc_e, ePc);
            chk("pcplus_e", m.pcplus_e, ePcp);
            chk("link_e", m.link_e, eLink);
        end
    endtask

    initial begin
        foreach (rf[i]) rf[i] = '0;
        eKnown = 0; expValid = 0; expCtrl = '0;
        rst = 1;
        m.valid_d = 1; m.instr_d = '0; m.pc_d = '0; m.pcplus_d = '0; m.ctrl_d = 12'hFFF;
        m.stall = 1; m.flush = 0; m.fwd_sel = '0;
        m.wb_we = 1; m.wb_addr = 5; m.wb_data = 18'h1234;
        cycle();
        cycle();
        chk("reset_valid", m.valid_e, 0);
        chk("reset_ctrl", m.ctrl_e, 0);
        chk("reset_pc", m.pc_e, 0);

        rst = 0; m.stall = 0; m.wb_we = 0; m.ctrl_d = 12'h123;
        m.instr_d = mk(0, 2'b00, 2'b10, 5'd5, 5'd0, 18'd0);
        cycle();
        chk("r5_after_rst", m.rd1_e, 0);

        m.wb_we = 1; m.wb_addr = 7; m.wb_data = 18'h2A5A;
        m.instr_d = mk(0, 2'b00, 2'b10, 5'd7, 5'd1, 18'd2);
        cycle();
        chk("bypass_rd1", m.rd1_e, 18'h2A5A);
        chk("sweep_bypass_rd1", s.rd1_e, 32'h2A5A);
        m.wb_we = 0; m.fwd_sel = 3'b001; m.wb_data = 18'h00FF;
        cycle();
        chk("fwd_rd1", m.rd1_e, 18'h00FF);
        chk("sweep_fwd_rd1", s.rd1_e, 32'h00FF);
        m.fwd_sel = '0;

        m.instr_d = mk(0, 2'b10, 2'b01, 5'd1, 5'd2, 18'd3);
        m.pc_d = 9'h1F0; m.pcplus_d = 9'h1F1;
        m.wb_we = 1; m.wb_addr = 29; m.wb_data = 18'h3;
        cycle();
        m.wb_we = 0;
        m.instr_d = mk(0, 2'b11, 2'b00, 5'd3, 5'd4, 18'd5);
        m.pc_d = 9'h010;
        cycle();
        chk("ret_rs1", m.rs1_e, 29);
        chk("ret_rd1", m.rd1_e, 18'h001F0);
        chk("sweep_ret_rs1", s.rs1_e, 13);
        chk("sweep_ret_rd1", s.rd1_e, 32'h1F0);

        m.instr_d = mk(1, 2'b00, 2'b00, 5'd7, 5'd9, 18'h3ABCD);
        m.pc_d = 9'h055; m.ctrl_d = 12'h5A5;
        cycle();
        m.stall = 1;
        m.instr_d = mk(0, 2'b10, 2'b01, 5'd2, 5'd2, 18'd2);
        m.pc_d = 9'h0AB; m.ctrl_d = 12'h0F0;
        repeat (3) begin
            cycle();
            chk("stall_pc_hold", m.pc_e, 9'h055);
            chk("stall_ctrl_hold", m.ctrl_e, 12'h5A5);
        end
        m.stall = 0;
        m.instr_d = mk(0, 2'b11, 2'b00, 5'd0, 5'd0, 18'd0);
        cycle();
        chk("stall_no_link", m.rd1_e, 18'h001F0);
        m.stall = 1; m.flush = 1;
        cycle();
        chk("flush_valid", m.valid_e, 0);
        chk("flush_ctrl", m.ctrl_e, 0);
        m.stall = 0; m.flush = 0;

        m.wb_we = 1; m.wb_addr = 0; m.wb_data = 18'h3FFFF;
        m.instr_d = mk(0, 2'b00, 2'b11, 5'd0, 5'd0, 18'd0);
        cycle();
        chk("r0_same_cycle", m.rd1_e, 0);
        m.wb_we = 0;
        cycle();
        chk("r0_after", m.rd1_e, 0);

        m.ctrl_d = 12'hABC;
        cycle();
        m.stall = 1; rst = 1;
        cycle();
        chk("rst_stall_valid", m.valid_e, 0);
        rst = 0;
        cycle();
        chk("rst_stall_no_resume", m.valid_e, 0);
        m.stall = 0; m.valid_d = 0;
        cycle();
        chk("rst_stall_empty", m.valid_e, 0);

        for (int n = 0; n < 400; n++) begin
            rst       = $urandom_range(0, 99) == 0;
            m.valid_d = $urandom_range(0, 9) != 0;
            m.stall   = $urandom_range(0, 4) == 0;
            m.flush   = $urandom_range(0, 9) == 0;
            if (m.stall && !m.flush) m.valid_d = 1;
            m.instr_d  = {1'($urandom), 32'($urandom)};
            m.pc_d     = PW'($urandom);
            m.pcplus_d = PW'($urandom);
            m.ctrl_d   = CW'($urandom);
            m.wb_we    = 1'($urandom);
            m.wb_addr  = $urandom_range(0, 3) == 0 ? AW'(LR) : AW'($urandom);
            m.wb_data  = DW'($urandom);
            m.fwd_sel  = 3'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_pipe_stage.md
DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 Parameters: DATA_W 18 data width; PC_W 9 PC width; ADDR_W 5 register address width; NREGS 32 register count; CTRL_W 12 control bundle width; LINK_REG 29 link register index.
REQ-002 Ports, one per line: name direction width meaning.
REQ-003 clk in 1 single clock; reset is synchronous and active-high.
REQ-004 rst in 1 synchronous active-high reset.
REQ-005 valid_d in 1 instr_d/pc_d/pcplus_d hold a real instruction.
REQ-006 instr_d in 33 instruction: [32] imm flag, [31:30] type, [29:28] op, [27:23] rs1, [22:18] rs2/rd, [4:0] rs4/rd, [17:0] imm.
REQ-007 pc_d, pcplus_d in PC_W each, PC and next PC of instr_d.
REQ-008 ctrl_d in CTRL_W decoded control bundle from the control unit.
REQ-009 stall in 1 hold the E register; flush in 1 insert a bubble into E.
REQ-010 wb_we in 1, wb_addr in ADDR_W, wb_data in DATA_W: write-back port.
REQ-011 fwd_sel in 3 per-read-port select, [0] rs1, [1] rs2, [2] rs4; 1 selects wb_data.
REQ-012 valid_e out 1; ctrl_e out CTRL_W; rd1_e/rd2_e/rd4_e/imm_e out DATA_W each; rs1_e/rs2_e/rs4_e/rd_e out ADDR_W each; pc_e/pcplus_e/link_e out PC_W each.

Function
REQ-013 Source A1 SHALL be LINK_REG when type=11 and op=00 (return); otherwise it SHALL be instr[27:23].
REQ-014 A2 SHALL be instr[4:0] when imm=0, type=01, op=00; otherwise it SHALL be instr[22:18].
REQ-015 A4 SHALL always be instr[4:0].
REQ-016 rd SHALL be instr[22:18] when (type=01, op=00) or (imm=1, type≠11, op=00); otherwise it SHALL be instr[4:0].
REQ-017 The register file SHALL be read combinationally, with three read ports plus a dedicated LINK_REG read.
REQ-018 The register file SHALL write on the rising edge.
REQ-019 A read of an address being written in the same cycle SHALL return the new data (internal bypass).
REQ-020 Register 0 SHALL read as 0, and writes to register 0 SHALL be ignored.
REQ-021 Link write: when valid_d=1, type=10, op=01 (call), and the stage advances (stall=0, flush=0), LINK_REG SHALL be written with the zero-extended pc_d at that edge.
REQ-022 If wb_we targets LINK_REG in the same cycle as a link write, the link write SHALL win.
REQ-023 A wb_we to any other address SHALL proceed in parallel with a link write.
REQ-024 After the fwd_sel muxes, each operand SHALL equal wb_data when its select bit is 1, and the register-file value otherwise.
REQ-025 The E register SHALL update each edge from the decoded fields, valid_e=valid_d, imm_e=instr[17:0], link_e=LINK_REG[PC_W-1:0].
REQ-026 Latency from D inputs to E outputs SHALL be exactly 1 cycle.
REQ-027 stall=1 SHALL hold all E outputs unchanged.
REQ-028 flush=1 SHALL set valid_e=0 and ctrl_e=0; other E fields are don't-care.
REQ-029 flush SHALL have priority over stall.
REQ-030 valid_d=0 SHALL load a bubble, with the same effect as flush.
REQ-031 Register-file writes from wb_we SHALL occur regardless of stall or flush.
REQ-032 Link writes SHALL be suppressed by stall, flush, or valid_d=0.

Reset
REQ-033 With rst=1 at an edge, all E outputs SHALL be set to 0, including valid_e=0 and ctrl_e=0.
REQ-034 Reset SHALL clear all registers to 0.
REQ-035 Reset SHALL dominate wb_we, link write, stall and flush in that cycle.
REQ-036 Reset asserted mid-stall SHALL leave the stage empty after the edge.
REQ-037 Reset asserted mid-stall SHALL not resume the held instruction after rst is released.

Structure
REQ-038 A shared package SHALL hold: type and op encodings (ALU=00, MEM=01, BR=10, RET=11; CALL op=01), the instruction field bit positions, and the default LINK_REG constant.
REQ-039 There SHALL be one sub-module, reg_file_param (parametrised NREGS/DATA_W, three read ports, link read, two write ports with link priority).
REQ-040 All other logic SHALL stay in decode_pipe_stage.

Verification
REQ-041 Reset: hold rst=1 with wb_we=1 to r5 -> all E outputs are 0 and r5 reads 0 after rst drops.
REQ-042 Bypass/forward: wb_we r7=0x2A5A in the same cycle that rs1=7 is decoded -> rd1_e=0x2A5A next cycle; with fwd_sel[0]=1 and wb_data=0x00FF -> rd1_e=0x00FF.
REQ-043 Call then return: call at pc_d=0x1F0 -> LINK_REG=0x1F0; a following return gives rs1_e=29 and rd1_e=0x001F0; a simultaneous wb_we to r29=0x3 -> LINK_REG=0x1F0.
REQ-044 Stall/flush: stall for 3 cycles -> E outputs are constant and no link write occurs; stall=1 with flush=1 -> valid_e=0 and ctrl_e=0.
REQ-045 Register 0: wb_we r0=0x3FFFF -> a read of r0 gives 0.
REQ-046 Parameter sweep: DATA_W=32, NREGS=16, ADDR_W=4, LINK_REG=13 -> REQ-042 and REQ-043 pass.
